// File: rtl/ttt_pkg.sv
// Shared types and tables for the scripted tic-tac-toe human player.
// Squares are numbered 1..9; square n lives in board bit n-1.
package ttt_pkg;

   typedef enum logic [1:0] {
      IDLE       = 2'd0,
      HUMAN_TURN = 2'd1,
      WAIT_CPU   = 2'd2,
      GAME_OVER  = 2'd3
   } player_state_t;

   localparam logic [3:0] NO_MOVE     = 4'hF;
   localparam logic [3:0] LAST_SQUARE = 4'd9;

   // Element [0] is the most preferred square.
   localparam logic [8:0][3:0] PICK_ORDER = {
      4'd8, 4'd6, 4'd4, 4'd2, 4'd9, 4'd7, 4'd3, 4'd1, 4'd5
   };

   localparam logic [7:0][2:0][3:0] WIN_LINES = {
      {4'd7, 4'd5, 4'd3},
      {4'd9, 4'd5, 4'd1},
      {4'd9, 4'd6, 4'd3},
      {4'd8, 4'd5, 4'd2},
      {4'd7, 4'd4, 4'd1},
      {4'd9, 4'd8, 4'd7},
      {4'd6, 4'd5, 4'd4},
      {4'd3, 4'd2, 4'd1}
   };

   // One-hot board mask for a square; anything outside 1..9 gives an empty mask.
   function automatic logic [8:0] sq_mask(input logic [3:0] sq);
      sq_mask = (sq >= 4'd1 && sq <= LAST_SQUARE) ? (9'd1 << (sq - 4'd1)) : 9'd0;
   endfunction

endpackage

// File: rtl/ttt_human_player_if.sv
// Game-level signals between the human player and whatever drives/observes it.
interface ttt_human_player_if;
   logic       start;
   logic [3:0] cMove;
   logic       win;
   logic [3:0] hMove;
   logic       done;
   logic       error;
   logic [3:0] moveCount;

   modport master (output start, cMove, win, input hMove, done, error, moveCount);
   modport slave  (input start, cMove, win, output hMove, done, error, moveCount);
endinterface

// File: rtl/ttt_move_picker.sv
// Combinational square chooser. Define TTT_WIN_BLOCK_EN to try winning,
// then blocking, before falling back to the fixed preference order.
module ttt_move_picker
   import ttt_pkg::*;
(
   input  logic [8:0] hBoard,
   input  logic [8:0] cBoard,
   output logic [3:0] square
);

   logic [8:0] occupied;
   logic [3:0] order_pick;

   assign occupied = hBoard | cBoard;

   // Scan from least to most preferred so the most preferred free square wins.
   always_comb begin
      order_pick = NO_MOVE;
      for (int i = 8; i >= 0; i--) begin
         if ((occupied & sq_mask(PICK_ORDER[i])) == 9'd0) order_pick = PICK_ORDER[i];
      end
   end

`ifdef TTT_WIN_BLOCK_EN
   logic [8:0] win_sq, block_sq;
   logic [8:0] ms, m1, m2;
   logic [3:0] win_pick, block_pick;

   // A free square whose two line-mates belong to one side completes or blocks that line.
   always_comb begin
      win_sq   = 9'd0;
      block_sq = 9'd0;
      ms       = 9'd0;
      m1       = 9'd0;
      m2       = 9'd0;
      for (int l = 0; l < 8; l++) begin
         for (int k = 0; k < 3; k++) begin
            ms = sq_mask(WIN_LINES[l][k]);
            m1 = sq_mask(WIN_LINES[l][(k + 1) % 3]);
            m2 = sq_mask(WIN_LINES[l][(k + 2) % 3]);
            if ((occupied & ms) == 9'd0) begin
               if ((hBoard & (m1 | m2)) == (m1 | m2)) win_sq   = win_sq | ms;
               if ((cBoard & (m1 | m2)) == (m1 | m2)) block_sq = block_sq | ms;
            end
         end
      end
   end

   function automatic logic [3:0] lowest_sq(input logic [8:0] mask);
      lowest_sq = NO_MOVE;
      for (int i = 8; i >= 0; i--) begin
         if (mask[i]) lowest_sq = 4'(i + 1);
      end
   endfunction

   assign win_pick   = lowest_sq(win_sq);
   assign block_pick = lowest_sq(block_sq);
   assign square     = (win_pick != NO_MOVE)   ? win_pick   :
                       (block_pick != NO_MOVE) ? block_pick : order_pick;
`else
   assign square = order_pick;
`endif

endmodule

// File: rtl/ttt_human_player.sv
// Scripted human opponent: plays a legal square each turn, polices the computer's
// moves and reports game completion. Optional smarter picking via TTT_WIN_BLOCK_EN.
module ttt_human_player
   import ttt_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 8
) (
   input  logic                clock,
   input  logic                reset,
   ttt_human_player_if.slave   bus
);

   player_state_t state, next_state;
   logic [8:0]    hBoard, cBoard;
   logic [3:0]    cPrev;
   logic [3:0]    move_count;
   logic          error_q;
   logic [3:0]    tmo;

   logic [3:0] pick;
   logic [3:0] cm;
   logic       new_move, in_range, sq_free, legal, bad, to_none, timeout, board_full_next;

   ttt_move_picker u_picker (
      .hBoard (hBoard),
      .cBoard (cBoard),
      .square (pick)
   );

   assign cm              = bus.cMove;
   assign new_move        = (cm != cPrev);
   assign in_range        = (cm >= 4'd1) && (cm <= LAST_SQUARE);
   assign sq_free         = ((hBoard | cBoard) & sq_mask(cm)) == 9'd0;
   assign legal           = new_move && in_range && sq_free;
   assign bad             = new_move && (cm != NO_MOVE) && !(in_range && sq_free);
   assign to_none         = new_move && (cm == NO_MOVE);
   // Fires on the TIMEOUT_CYCLES-th consecutive wait cycle without a new move.
   assign timeout         = (int'({1'b0, tmo}) + 1) >= TIMEOUT_CYCLES;
   assign board_full_next = (move_count + 4'd1) == LAST_SQUARE;

   always_ff @(posedge clock) begin
      if (!reset) state <= IDLE;
      else        state <= next_state;
   end

   always_comb begin
      next_state = state;
      unique case (state)
         IDLE, GAME_OVER: if (bus.start) next_state = HUMAN_TURN;
         HUMAN_TURN:      next_state = board_full_next ? GAME_OVER : WAIT_CPU;
         WAIT_CPU: begin
            if (bus.win)      next_state = GAME_OVER;
            else if (legal)   next_state = board_full_next ? GAME_OVER : HUMAN_TURN;
            else if (bad)     next_state = GAME_OVER;
            else if (to_none) next_state = WAIT_CPU;
            else if (timeout) next_state = GAME_OVER;
         end
         default:         next_state = IDLE;
      endcase
   end

   always_comb begin
      bus.hMove     = (state == HUMAN_TURN) ? pick : NO_MOVE;
      bus.done      = (state == GAME_OVER);
      bus.error     = error_q;
      bus.moveCount = move_count;
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         hBoard     <= 9'd0;
         cBoard     <= 9'd0;
         cPrev      <= NO_MOVE;
         move_count <= 4'd0;
         error_q    <= 1'b0;
         tmo        <= 4'd0;
      end else begin
         unique case (state)
            IDLE, GAME_OVER: begin
               if (bus.start) begin
                  hBoard     <= 9'd0;
                  cBoard     <= 9'd0;
                  move_count <= 4'd0;
                  error_q    <= 1'b0;
                  cPrev      <= cm;
               end
            end
            HUMAN_TURN: begin
               hBoard     <= hBoard | sq_mask(pick);
               move_count <= move_count + 4'd1;
               tmo        <= 4'd0;
            end
            WAIT_CPU: begin
               if (tmo != 4'hF) tmo <= tmo + 4'd1;
               // win pre-empts everything, including recording a simultaneous move.
               if (!bus.win) begin
                  if (legal) begin
                     cBoard     <= cBoard | sq_mask(cm);
                     move_count <= move_count + 4'd1;
                     cPrev      <= cm;
                  end else if (bad) begin
                     error_q <= 1'b1;
                  end else if (to_none) begin
                     cPrev <= cm;
                  end else if (timeout) begin
                     error_q <= 1'b1;
                  end
               end
            end
            default: ;
         endcase
      end
   end

endmodule
